// File: rtl/ss_decoder_if.sv
// rtl/ss_decoder_if.sv - segment bus in, decoded value and status flags out
interface ss_decoder_if #(
  parameter int DIGITS = 4
);
  logic [7*DIGITS-1:0] ss_in;
  logic [4*DIGITS-1:0] value_out;
  logic                valid;
  logic                changed;
  logic                error;

  modport master (
    output ss_in,
    input  value_out,
    input  valid,
    input  changed,
    input  error
  );

  modport slave (
    input  ss_in,
    output value_out,
    output valid,
    output changed,
    output error
  );
endinterface

// File: rtl/ss_decoder.sv
// rtl/ss_decoder.sv - active-low 7-segment bank to hex digits, one shared decoder
// scanned across the digits once the bus has been stable long enough.
module ss_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          resetN,
  ss_decoder_if.slave  bus
);

  localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]     CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT,
    HOLD
  } state_t;

  state_t              state;
  logic [7*DIGITS-1:0] ss_q;
  logic [7:0]          cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow;
  logic                shadow_err;
  logic [4*DIGITS-1:0] value_r;
  logic                valid_r;
  logic                changed_r;
  logic                error_r;
  logic                in_diff;
  logic [6:0]          cur_code;
  logic [3:0]          dec_val;
  logic                dec_err;

  assign in_diff = (bus.ss_in != ss_q);

  // Returns {error, value}; blank is a legal all-off digit that reads as 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    case (code)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b0001000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
      7'b1111111: return 5'h00;
      default:    return 5'h10;
    endcase
  endfunction

  always_comb begin
    cur_code = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) cur_code = ss_q[7*i +: 7];
    end
  end

  assign {dec_err, dec_val} = seg_decode(cur_code);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ss_q <= '1;
      cnt  <= '0;
    end else begin
      ss_q <= bus.ss_in;
      if (in_diff)
        cnt <= '0;
      else if (cnt < CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  // Entry to SCAN also demands the bus is still unchanged this cycle, and a
  // change seen during COMMIT sends us back to IDLE so it is not lost in HOLD.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      shadow_err <= 1'b0;
      value_r    <= '0;
      valid_r    <= 1'b0;
      changed_r  <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      changed_r <= 1'b0;
      case (state)
        IDLE: begin
          if (cnt == CNT_MAX && !in_diff) begin
            state      <= SCAN;
            idx        <= '0;
            shadow     <= '0;
            shadow_err <= 1'b0;
          end
        end
        SCAN: begin
          if (in_diff) begin
            state <= IDLE;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (idx == IW'(i)) shadow[4*i +: 4] <= dec_val;
            end
            shadow_err <= shadow_err | dec_err;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= COMMIT;
          end
        end
        COMMIT: begin
          value_r   <= shadow;
          error_r   <= shadow_err;
          valid_r   <= 1'b1;
          changed_r <= (shadow != value_r) || !valid_r;
          state     <= in_diff ? IDLE : HOLD;
        end
        HOLD: begin
          if (in_diff) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.value_out = value_r;
  assign bus.valid     = valid_r;
  assign bus.changed   = changed_r;
  assign bus.error     = error_r;

endmodule

// File: doc/ss_decoder.md
# ss_decoder

Recovers hexadecimal digit values from a bank of active-low 7-segment codes, the inverse of the team's hex-to-7-segment encoder. The block watches the segment bus, waits for it to be stable, and decodes one digit per cycle through a single shared decoder. It then publishes a registered multi-digit value with valid, change and error flags. It sits between the score/display path and the self-check and loopback logic, so the bench and on-chip monitors can read back what the display is actually showing.

## Interface
- DIGITS, 4, number of 7-segment digits on the bus (1..8)
- STABLE_CYCLES, 4, consecutive unchanged cycles required before decoding (1..255)
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- ss_in  in  7*DIGITS  segment codes, active-low; digit i in bits [7i+6:7i]; bit order matches the encoder (bit0=a … bit6=g)
- value_out  out  4*DIGITS  decoded digits; digit i in bits [4i+3:4i]
- valid  out  1  high once at least one value has been committed since reset
- changed  out  1  one-cycle pulse when a commit alters value_out, or on the first commit
- error  out  1  set at commit if any digit held an unrecognised pattern; holds until the next commit

## Operation
- Code table (code→value): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
- Blank pattern 1111111 decodes to 0 with no error.
- Any other pattern decodes to 0 and marks the digit as an error.
- ss_q register: captures ss_in every cycle; reset value all ones (blank).
- Stability counter cnt, width 8:
  - If ss_in ≠ ss_q, cnt←0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - Reset value 0.
- State machine, reset state IDLE:
  - IDLE: when cnt==STABLE_CYCLES, go to SCAN with idx←0 and clear the shadow value and shadow error.
  - SCAN: decode ss_q digit idx into shadow[idx], OR its error into shadow_err, then idx←idx+1. After decoding idx==DIGITS-1, go to COMMIT. If ss_in ≠ ss_q in any SCAN cycle, abort to IDLE; shadow is discarded and outputs are untouched.
  - COMMIT: value_out←shadow, error←shadow_err, valid←1. changed←1 if shadow ≠ value_out or valid was 0; otherwise changed←0. Go to HOLD.
  - HOLD: changed←0. If ss_in ≠ ss_q, go to IDLE. No re-decode while the input stays stable.
- changed is low in every state except the cycle after COMMIT.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). The prior value is lost.

## Timing
- Reset values: value_out=0, valid=0, changed=0, error=0, state=IDLE, cnt=0, idx=0, ss_q=all ones.
- Let ss_in take a new value just before edge E and then hold it. Schedule:
  - Edge E: cnt←0.
  - Edge E+STABLE_CYCLES: cnt reaches STABLE_CYCLES.
  - Edge E+STABLE_CYCLES+1: enter SCAN.
  - Edges E+STABLE_CYCLES+2 … E+STABLE_CYCLES+1+DIGITS: decode digits 0..DIGITS-1.
  - Edge E+STABLE_CYCLES+DIGITS+2: outputs update and the changed pulse begins.
- Latency: STABLE_CYCLES+DIGITS+2 cycles from input change to visible outputs; 10 with defaults.
- changed stays high for exactly one cycle, clearing on the following edge.
- An input change in the same cycle as the final SCAN decode still aborts; COMMIT is not entered.
- An input that changes at least every STABLE_CYCLES cycles never commits; outputs hold their last committed values.
- Width rules:
  - value_out is compared as the full 4*DIGITS vector.
  - idx is ceil(log2(DIGITS)) bits wide, minimum 1.
  - cnt saturates and never wraps.

## Test plan
- Reset: assert resetN=0 mid-stream → all outputs 0 and state IDLE within the same cycle. Release with ss_in all blank → after 10 cycles value_out=0x0000, valid=1, changed pulses once, error=0.
- Steady digits: ss_in = codes for 4,3,2,1 (digit3..0) held → at edge E+10 value_out=0x4321, valid=1, error=0, one-cycle changed pulse. No further pulses while the input is held.
- Glitching: toggle ss_in between codes for 0x1111 and 0x2222 every 3 cycles for 50 cycles → no commit, value_out unchanged, changed never asserted. Then hold 0x2222 → commit 10 cycles after the last toggle.
- Mid-scan change: change digit 2 during the second SCAN cycle → abort. value_out updates to the new value exactly 10 cycles after the change edge, with no intermediate commit.
- Invalid pattern: digit 1 = 0101010, others = code for 5 → value_out=0x5505, error=1. A later valid stable input clears error at its commit.
- Blank vs zero: commit 0x0000 using code 0 on all digits, then switch digit 3 to blank → the recommit occurs with value_out=0x0000, changed=0 and error=0.
